// File: rtl/clock_time_keeper_if.sv
// Button inputs and BCD time outputs of the timekeeping core.
// The master side drives the buttons; the slave side is the timekeeper.
interface clock_time_keeper_if;
    logic       hour_inc;
    logic       min_inc;
    logic [1:0] hour_tens;
    logic [3:0] hour_ones;
    logic [2:0] min_tens;
    logic [3:0] min_ones;
    logic [2:0] sec_tens;
    logic [3:0] sec_ones;
    logic       tick_1hz;
    logic       changed;

    modport master (
        output hour_inc, min_inc,
        input  hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones,
        input  tick_1hz, changed
    );

    modport slave (
        input  hour_inc, min_inc,
        output hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones,
        output tick_1hz, changed
    );
endinterface

// File: rtl/clock_time_keeper.sv
// 24-hour BCD timekeeper: 1 Hz prescaler, debounced hour/minute set buttons,
// and a one-cycle change strobe for the display stage.
module clock_time_keeper #(
    parameter int CLOCK_RATE      = 1000,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    clock_time_keeper_if.slave tk
);
    localparam int PRE_W    = $clog2(CLOCK_RATE);
    localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BTN_MIN  = 0;
    localparam int BTN_HOUR = 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLOCK_RATE - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef struct packed {
        logic [1:0] hour_tens;
        logic [3:0] hour_ones;
        logic [2:0] min_tens;
        logic [3:0] min_ones;
        logic [2:0] sec_tens;
        logic [3:0] sec_ones;
    } bcd_time_t;

    bcd_time_t        time_q, time_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick_q, changed_q;
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       level_q, level_d;
    logic [1:0]       req_q, req_d;
    logic [DB_W-1:0]  cnt_q [2];
    logic [DB_W-1:0]  cnt_d [2];

    logic wrap, sec_carry, min_at_last, min_step, hour_step;

    // Shared by seconds and minutes: 00..59 in BCD.
    function automatic logic [6:0] inc_mod60(input logic [2:0] tens, input logic [3:0] ones);
        if (ones != 4'd9) return {tens, ones + 4'd1};
        if (tens != 3'd5) return {tens + 3'd1, 4'd0};
        return 7'd0;
    endfunction

    function automatic logic [5:0] inc_hour(input logic [1:0] tens, input logic [3:0] ones);
        if (tens == 2'd2 && ones == 4'd3) return 6'd0;
        if (ones == 4'd9)                 return {tens + 2'd1, 4'd0};
        return {tens, ones + 4'd1};
    endfunction

    // A level change is accepted after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            // NOTE: every _d takes its hold value before any condition, so no path can infer a latch.
            level_d[b] = level_q[b];
            req_d[b]   = 1'b0;
            cnt_d[b]   = '0;
            if (sync2_q[b] != level_q[b]) begin
                if (cnt_q[b] == DB_LAST) begin
                    level_d[b] = ~level_q[b];
                    req_d[b]   = ~level_q[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + DB_W'(1);
                end
            end
        end
    end

    always_comb begin
        time_d      = time_q;
        pre_d       = pre_q + PRE_W'(1);
        wrap        = (pre_q == PRE_LAST);
        sec_carry   = wrap && time_q.sec_tens == 3'd5 && time_q.sec_ones == 4'd9;
        min_at_last = time_q.min_tens == 3'd5 && time_q.min_ones == 4'd9;
        // A manual minute step swallows the tick's minute (and hence hour) carry.
        min_step    = req_q[BTN_MIN] || sec_carry;
        hour_step   = req_q[BTN_HOUR] || (sec_carry && min_at_last && !req_q[BTN_MIN]);

        if (wrap || req_q[BTN_MIN]) pre_d = '0;

        if (req_q[BTN_MIN])
            {time_d.sec_tens, time_d.sec_ones} = '0;
        else if (wrap)
            {time_d.sec_tens, time_d.sec_ones} = inc_mod60(time_q.sec_tens, time_q.sec_ones);

        if (min_step)
            {time_d.min_tens, time_d.min_ones} = inc_mod60(time_q.min_tens, time_q.min_ones);
        if (hour_step)
            {time_d.hour_tens, time_d.hour_ones} = inc_hour(time_q.hour_tens, time_q.hour_ones);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            time_q    <= '0;
            pre_q     <= '0;
            tick_q    <= 1'b0;
            changed_q <= 1'b0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            req_q     <= '0;
            cnt_q     <= '{default: '0};
        end else begin
            // NOTE: non-blocking updates so every flop samples the values from before this edge.
            time_q    <= time_d;
            pre_q     <= pre_d;
            tick_q    <= wrap;
            changed_q <= (time_d != time_q);
            sync1_q   <= {tk.hour_inc, tk.min_inc};
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            req_q     <= req_d;
            cnt_q     <= cnt_d;
        end
    end

    assign tk.hour_tens = time_q.hour_tens;
    assign tk.hour_ones = time_q.hour_ones;
    assign tk.min_tens  = time_q.min_tens;
    assign tk.min_ones  = time_q.min_ones;
    assign tk.sec_tens  = time_q.sec_tens;
    assign tk.sec_ones  = time_q.sec_ones;
    assign tk.tick_1hz  = tick_q;
    assign tk.changed   = changed_q;
endmodule

// File: tb/tb_clock_time_keeper.sv
// Bench for clock_time_keeper: directed scenarios plus random button traffic,
// checked every cycle against a seconds-since-midnight reference model.
module tb_clock_time_keeper;
    localparam int CR = 4;
    localparam int DB = 3;
    // Holding a button from a state with prescaler=2 lands its request D+2 edges
    // later exactly on a prescaler wrap, after one intervening wrap.
    localparam int COINCIDE_PRE = 2;
    localparam int COINCIDE_SEC = 58;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    clock_time_keeper_if tk ();

    clock_time_keeper #(.CLOCK_RATE(CR), .DEBOUNCE_CYCLES(DB)) dut (
        .clk  (clk),
        .reset(reset),
        .tk   (tk)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Reference model: time as seconds since midnight, buttons as delayed samples
    // that must disagree with the accepted level for DB consecutive cycles.
    int m_secs, m_pre;
    bit m_tick, m_chg;
    bit m_s1 [2];
    bit m_s2 [2];
    bit m_lvl[2];
    bit m_req[2];
    int m_run[2];

    task automatic model_reset();
        m_secs = 0; m_pre = 0; m_tick = 0; m_chg = 0;
        for (int b = 0; b < 2; b++) begin
            m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_req[b] = 0; m_run[b] = 0;
        end
    endtask

    task automatic model_edge(input bit r, input bit raw_min, input bit raw_hour);
        int h, mi, s, old;
        bit wrap, hour_carry;
        bit raw[2];
        if (r) begin
            model_reset();
            return;
        end
        raw[0] = raw_min; raw[1] = raw_hour;
        old  = m_secs;
        h    = m_secs / 3600;
        mi   = (m_secs / 60) % 60;
        s    = m_secs % 60;
        wrap = (m_pre == CR - 1);
        hour_carry = 0;
        if (m_req[0]) begin
            mi = (mi + 1) % 60;
            s  = 0;
        end else if (wrap) begin
            s++;
            if (s == 60) begin
                s = 0; mi++;
                if (mi == 60) begin mi = 0; hour_carry = 1; end
            end
        end
        if (m_req[1] || hour_carry) h = (h + 1) % 24;
        m_pre  = (wrap || m_req[0]) ? 0 : m_pre + 1;
        m_secs = h * 3600 + mi * 60 + s;
        m_tick = wrap;
        m_chg  = (m_secs != old);
        for (int b = 0; b < 2; b++) begin
            m_req[b] = 0;
            if (m_s2[b] != m_lvl[b]) m_run[b]++;
            else                     m_run[b] = 0;
            if (m_run[b] == DB) begin
                m_lvl[b] = !m_lvl[b];
                m_run[b] = 0;
                m_req[b] = m_lvl[b];
            end
            m_s2[b] = m_s1[b];
            m_s1[b] = raw[b];
        end
    endtask

    function automatic logic [19:0] bcd(input int h, input int mi, input int s);
        return {2'(h / 10), 4'(h % 10), 3'(mi / 10), 4'(mi % 10), 3'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [19:0] got_time();
        return {tk.hour_tens, tk.hour_ones, tk.min_tens, tk.min_ones, tk.sec_tens, tk.sec_ones};
    endfunction

    function automatic int m_h();  return m_secs / 3600;        endfunction
    function automatic int m_m();  return (m_secs / 60) % 60;   endfunction
    function automatic int m_s();  return m_secs % 60;          endfunction

    // Drive inputs, take one edge, then compare at the falling edge.
    task automatic step(input bit r, input bit bm, input bit bh);
        reset = r; tk.min_inc = bm; tk.hour_inc = bh;
        @(posedge clk);
        model_edge(r, bm, bh);
        @(negedge clk);
        check("digits",  32'(got_time()),   32'(bcd(m_h(), m_m(), m_s())));
        check("tick",    32'(tk.tick_1hz),  32'(m_tick));
        check("changed", 32'(tk.changed),   32'(m_chg));
    endtask

    task automatic press(input int b);
        for (int i = 0; i < DB + 4; i++) step(0, b == 0, b == 1);
        for (int i = 0; i < DB + 4; i++) step(0, 0, 0);
    endtask

    task automatic set_hm(input int h, input int mi);
        for (int n = 0; n < 30 && m_h() != h; n++)  press(1);
        for (int n = 0; n < 70 && m_m() != mi; n++) press(0);
    endtask

    task automatic wait_until(input string tag, input int h, input int mi, input int s, input int p);
        for (int n = 0; n < 1000; n++) begin
            if (m_h() == h && m_m() == mi && m_s() == s && m_pre == p) break;
            step(0, 0, 0);
        end
        check(tag, 32'(got_time()), 32'(bcd(h, mi, s)));
    endtask

    initial begin
        int tick_seen, chg_seen, len;
        bit r, bm, bh;
        reset = 1'b1; tk.min_inc = 1'b0; tk.hour_inc = 1'b0;
        model_reset();

        // Reset state and free-running seconds.
        step(1, 0, 0);
        step(1, 0, 0);
        check("reset_time", 32'(got_time()), 32'(0));
        tick_seen = 0; chg_seen = 0;
        for (int i = 1; i <= 16; i++) begin
            step(0, 0, 0);
            tick_seen += int'(tk.tick_1hz);
            chg_seen  += int'(tk.changed);
            if (i % CR == 0) check("tick_slot", 32'(tk.tick_1hz), 32'(1));
        end
        check("run16_time", 32'(got_time()), 32'(bcd(0, 0, 4)));
        check("run16_ticks", 32'(tick_seen), 32'(4));
        check("run16_chg", 32'(chg_seen), 32'(4));

        // Glitch shorter than the debounce window.
        step(0, 1, 0);
        step(0, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0);
        check("glitch_min", 32'({tk.min_tens, tk.min_ones}), 32'(0));

        // Held press: minutes +1 after edge DB+2, seconds cleared, only once.
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0);
            if (i == DB + 1) check("db_early", 32'({tk.min_tens, tk.min_ones}), 32'(0));
            if (i == DB + 2) begin
                check("db_min", 32'({tk.min_tens, tk.min_ones}), 32'(1));
                check("db_sec", 32'({tk.sec_tens, tk.sec_ones}), 32'(0));
            end
        end
        for (int i = 0; i < 8; i++) step(0, 0, 0);
        check("db_once", 32'({tk.min_tens, tk.min_ones}), 32'(1));

        // Manual minute wrap 59 -> 00 does not carry into hours.
        set_hm(0, 59);
        wait_until("at_005930", 0, 59, 30, 0);
        for (int i = 0; i < DB + 4; i++) begin
            step(0, 1, 0);
            if (i == DB + 2) check("min_wrap", 32'(got_time()), 32'(bcd(0, 0, 0)));
        end

        // Day rollover.
        set_hm(23, 59);
        wait_until("at_235958", 23, 59, 58, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0);
            if (i == 3) begin
                check("roll_59", 32'(got_time()), 32'(bcd(23, 59, 59)));
                check("roll_59_chg", 32'(tk.changed), 32'(1));
            end
            if (i == 7) begin
                check("roll_00", 32'(got_time()), 32'(bcd(0, 0, 0)));
                check("roll_00_chg", 32'(tk.changed), 32'(1));
            end
        end

        // Minute press coinciding with a prescaler wrap at 12:34:59.
        set_hm(12, 34);
        wait_until("at_1234", 12, 34, COINCIDE_SEC, COINCIDE_PRE);
        for (int i = 0; i < DB + 4; i++) begin
            step(0, 1, 0);
            if (i == DB + 2) begin
                check("min_tick_time", 32'(got_time()), 32'(bcd(12, 35, 0)));
                check("min_tick_pulse", 32'(tk.tick_1hz), 32'(1));
            end
        end
        for (int i = 0; i < DB + 4; i++) step(0, 0, 0);

        // Hour press coinciding with the 59:59 carry at 05:59:59.
        set_hm(5, 59);
        wait_until("at_0559", 5, 59, COINCIDE_SEC, COINCIDE_PRE);
        for (int i = 0; i < DB + 4; i++) begin
            step(0, 0, 1);
            if (i == DB + 2) check("hour_carry_time", 32'(got_time()), 32'(bcd(6, 0, 0)));
        end
        for (int i = 0; i < DB + 4; i++) step(0, 0, 0);

        // Reset mid-count with a press in progress.
        set_hm(7, 42);
        wait_until("at_074213", 7, 42, 13, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        step(1, 0, 0);
        check("rst_time", 32'(got_time()), 32'(0));
        check("rst_tick", 32'(tk.tick_1hz), 32'(0));
        check("rst_chg", 32'(tk.changed), 32'(0));
        for (int i = 0; i < 10; i++) step(0, 0, 0);
        check("rst_discard", 32'(got_time()), 32'(bcd(0, 0, 2)));

        // Random button traffic with occasional resets.
        for (int seg = 0; seg < 400; seg++) begin
            bm  = ($urandom_range(0, 2) == 0);
            bh  = ($urandom_range(0, 3) == 0);
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                r = ($urandom_range(0, 299) == 0);
                step(r, bm, bh);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/clock_time_keeper.md
Name: clock_time_keeper

Overview:
Timekeeping core directly upstream of the lcd driver in the tinytapeout clock design. It debounces the raw hour_inc/min_inc buttons, runs a CLOCK_RATE prescaler to produce a 1 Hz tick, and maintains a 24-hour HH:MM:SS time as BCD digits. A one-cycle change strobe tells the display stage when to redraw.

Parameters:
CLOCK_RATE, 1000, clk cycles per second; must be >= 2.
DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples needed to accept a button level change; must be >= 1.

Ports:
clk  input  1  system clock, io_in[0] domain
reset  input  1  synchronous, active-high reset
hour_inc  input  1  raw asynchronous button, active-high
min_inc  input  1  raw asynchronous button, active-high
hour_tens  output  2  BCD 0..2
hour_ones  output  4  BCD 0..9 (0..3 when hour_tens==2)
min_tens  output  3  BCD 0..5
min_ones  output  4  BCD 0..9
sec_tens  output  3  BCD 0..5
sec_ones  output  4  BCD 0..9
tick_1hz  output  1  registered one-cycle pulse on each seconds advance
changed  output  1  registered one-cycle pulse whenever any digit register changed

Behaviour:
- Single clock domain. All state updates on the rising clk edge. Reset is synchronous, active-high, and dominates every other event.
- Reset values: all six digits 0 (00:00:00), tick_1hz=0, changed=0, prescaler=0, synchroniser flops 0, debounced levels 0, debounce counters 0.
- Prescaler:
  - Counts 0..CLOCK_RATE-1 and increments every cycle.
  - At the edge where it equals CLOCK_RATE-1, it loads 0 and a seconds advance occurs on that same edge.
  - tick_1hz is high for exactly the following cycle.
  - First advance after reset release is at edge CLOCK_RATE, counting the first post-reset edge as 1.
- Seconds advance:
  - sec_ones increments; 9 wraps to 0 with carry into sec_tens.
  - sec_tens 5 with sec_ones 9 wraps to 00 with carry into minutes.
  - Minutes behave the same way; 59 wraps to 00 with carry into hours.
  - Hours count 00..23; 23 wraps to 00. No carry out of hours.
- Button path (identical for each button):
  - Two-flop synchroniser, then a debounce counter.
  - While the synchronised sample differs from the debounced level, the counter increments; any cycle where they match clears the counter.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - The rising edge of the debounced level gives a one-cycle increment request. Falling edges produce nothing.
  - Latency: raw sampled high at edge 0 and held, so the digit update is visible after edge DEBOUNCE_CYCLES+2.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no request.
- min_inc request:
  - Minutes +1, wrapping 59->00 with no carry into hours.
  - Seconds cleared to 00 and prescaler cleared to 0 on the same edge.
- hour_inc request: hours +1, wrapping 23->00. Minutes, seconds and prescaler unaffected.
- Simultaneous events on the same edge:
  - min_inc request plus prescaler wrap: the manual path wins. Minutes advance by exactly 1, seconds=00, prescaler=0, and tick_1hz is still pulsed. Any minute carry from the tick is discarded.
  - hour_inc request plus a tick carry into hours: hours advance by exactly 1.
  - Both requests together: both applied independently.
- changed is high for the cycle after any edge where at least one digit register took a new value. It is never high when digits are unchanged (e.g. min_inc landing while seconds are already 00 still changes minutes, so changed=1).
- A button held high through reset release is treated as a fresh press: one increment after DEBOUNCE_CYCLES+2 edges.
- Digit outputs are driven directly from registers, with no combinational path from the inputs.

Test Plan:
- Reset, CLOCK_RATE=4, no buttons, run 16 edges -> digits 00:00:04; tick_1hz and changed pulse on the cycles after edges 4, 8, 12, 16; nothing between.
- Force time 23:59:58 (via min/hour presses), CLOCK_RATE=4, run 8 edges -> 23:59:59 then 00:00:00; changed pulses at both transitions.
- DEBOUNCE_CYCLES=3, min_inc high for 2 synchronised cycles, then low -> no change; held high 10 cycles -> minutes +1 exactly once, visible after edge 5 from first sample, seconds=00.
- Time 00:59:30, one min_inc press -> 00:00:00. Hours unchanged, no carry.
- Time 12:34:59, min_inc request coinciding with prescaler wrap -> 12:35:00 (not 12:36), tick_1hz pulsed; hour_inc coinciding with a 59:59 carry at 05:59:59 -> 06:00:00 (not 07).
- Assert reset mid-count at 07:42:13 with a debounce in progress -> next cycle 00:00:00, tick_1hz=0, changed=0; the in-progress press is discarded.
